// File: rtl/cordic_pkg.sv
// cordic_pkg: shared types and constants for the pipelined CORDIC engine.
// Holds the arctangent table, the 1/K gain constant, the mode enum and the per-stage control record.
package cordic_pkg;

    typedef enum logic {
        ROTATE = 1'b0,
        VECTOR = 1'b1
    } cordic_mode_t;

    // Control half of the stage record; x/y/z ride beside it at
    // widths fixed by the instantiating module.
    typedef struct packed {
        logic         valid;
        cordic_mode_t mode;
    } cordic_ctl_t;

    // Headroom above the input MSB: a full-scale diagonal grows by
    // sqrt(2)*K ~ 2.33 before gain compensation.
    localparam int XY_GROWTH = 2;

    // atan(2^-i) as a binary angle, 2^32 = 360 degrees.
    localparam logic [31:0] ATAN_TABLE [24] = '{
        32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2F9, 32'h0000_517C,
        32'h0000_28BE, 32'h0000_145F, 32'h0000_0A2F, 32'h0000_0517,
        32'h0000_028B, 32'h0000_0145, 32'h0000_00A2, 32'h0000_0051
    };

    // round(0.607253 * 2^23)
    localparam logic [23:0] INV_K_24 = 24'd5094007;

    // 1/K rescaled to Q1.(width-1) with round-to-nearest.
    function automatic logic [23:0] inv_k_scaled(input int width);
        logic [24:0] r;
        if (width >= 24) begin
            return INV_K_24;
        end
        r = {1'b0, INV_K_24} + (25'd1 << (23 - width));
        return 24'(r >> (24 - width));
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// cordic_stage: one registered CORDIC micro-rotation with hold enable.
// Ports: clk, reset (async low), advance (hold when 0), ctl/x/y/z in -> ctl/x/y/z out.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int STAGE_IDX = 0,
    parameter int XY_W      = 20,
    parameter int Z_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   advance,
    input  cordic_ctl_t            ctl_in,
    input  logic signed [XY_W-1:0] x_in,
    input  logic signed [XY_W-1:0] y_in,
    input  logic [Z_W-1:0]         z_in,
    output cordic_ctl_t            ctl_out,
    output logic signed [XY_W-1:0] x_out,
    output logic signed [XY_W-1:0] y_out,
    output logic [Z_W-1:0]         z_out
);

    localparam logic [31:0] ATAN_FULL = ATAN_TABLE[5'(STAGE_IDX)];
    localparam logic [Z_W-1:0] ATAN = ATAN_FULL[31 -: Z_W];

    cordic_ctl_t            ctl_d, ctl_q;
    logic signed [XY_W-1:0] x_d, x_q, y_d, y_q;
    logic signed [XY_W-1:0] x_sh, y_sh;
    logic [Z_W-1:0]         z_d, z_q;
    logic                   d_pos;

    always_comb begin
        x_sh  = x_in >>> STAGE_IDX;
        y_sh  = y_in >>> STAGE_IDX;
        // rotation drives z to 0, vectoring drives y to 0
        d_pos = (ctl_in.mode == ROTATE) ? !z_in[Z_W-1]
                                        : y_in[XY_W-1];
        ctl_d = ctl_q;
        x_d   = x_q;
        y_d   = y_q;
        z_d   = z_q;
        if (advance) begin
            ctl_d = ctl_in;
            if (d_pos) begin
                x_d = x_in - y_sh;
                y_d = y_in + x_sh;
                z_d = z_in - ATAN;
            end else begin
                x_d = x_in + y_sh;
                y_d = y_in - x_sh;
                z_d = z_in + ATAN;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctl_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            z_q   <= '0;
        end else begin
            ctl_q <= ctl_d;
            x_q   <= x_d;
            y_q   <= y_d;
            z_q   <= z_d;
        end
    end

    assign ctl_out = ctl_q;
    assign x_out   = x_q;
    assign y_out   = y_q;
    assign z_out   = z_q;

endmodule

// File: rtl/cordic_pipe_param.sv
// cordic_pipe_param: fully pipelined rotation/vectoring CORDIC with quadrant pre-rotation, optional 1/K gain and valid/ready backpressure.
// Ports: clk, reset (async low), in_valid/in_ready, mode, x/y/z_in -> out_valid/out_ready, mode_out, x/y/z_out.
module cordic_pipe_param
    import cordic_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int N_STAGES  = 16,
    parameter int GUARD     = 2,
    parameter int GAIN_COMP = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    mode,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0]        z_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    mode_out,
    output logic signed [WIDTH-1:0] x_out,
    output logic signed [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0]        z_out
);

    localparam int IW = WIDTH + GUARD + XY_GROWTH;
    localparam int PW = IW + WIDTH + 1;

    localparam logic [WIDTH-1:0] QUARTER = {2'b01, {(WIDTH-2){1'b0}}};
    localparam logic [WIDTH-1:0] INV_K_W = WIDTH'(inv_k_scaled(WIDTH));

    localparam logic signed [IW:0] RND    = (IW+1)'((2 ** GUARD) / 2);
    localparam logic signed [IW:0] SAT_HI = (IW+1)'((2 ** (WIDTH-1)) - 1);
    localparam logic signed [IW:0] SAT_LO = -SAT_HI;

    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // ---------------- pre-rotation stage ----------------
    cordic_ctl_t          p_ctl_d, p_ctl_q;
    cordic_mode_t         in_mode;
    logic signed [IW-1:0] x_ext, y_ext;
    logic signed [IW-1:0] p_x_d, p_x_q, p_y_d, p_y_q;
    logic [WIDTH-1:0]     p_z_d, p_z_q;

    always_comb begin
        in_mode = cordic_mode_t'(mode);
        x_ext   = IW'(x_in) <<< GUARD;
        y_ext   = IW'(y_in) <<< GUARD;
        p_ctl_d = p_ctl_q;
        p_x_d   = p_x_q;
        p_y_d   = p_y_q;
        p_z_d   = p_z_q;
        if (advance) begin
            p_ctl_d.valid = in_valid;
            p_ctl_d.mode  = in_mode;
            p_x_d = x_ext;
            p_y_d = y_ext;
            p_z_d = z_in;
            if (in_mode == ROTATE) begin
                // fold angles in [90,270) deg into the +-90 deg
                // convergence range of the micro-rotations
                unique case (z_in[WIDTH-1 -: 2])
                    2'b01: begin
                        p_x_d = -y_ext;
                        p_y_d = x_ext;
                        p_z_d = z_in - QUARTER;
                    end
                    2'b10: begin
                        p_x_d = y_ext;
                        p_y_d = -x_ext;
                        p_z_d = z_in + QUARTER;
                    end
                    default: ;
                endcase
            end else if (x_ext[IW-1]) begin
                // left half-plane: turn by -/+90 deg into x >= 0
                if (!y_ext[IW-1]) begin
                    p_x_d = y_ext;
                    p_y_d = -x_ext;
                    p_z_d = z_in + QUARTER;
                end else begin
                    p_x_d = -y_ext;
                    p_y_d = x_ext;
                    p_z_d = z_in - QUARTER;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_ctl_q <= '0;
            p_x_q   <= '0;
            p_y_q   <= '0;
            p_z_q   <= '0;
        end else begin
            p_ctl_q <= p_ctl_d;
            p_x_q   <= p_x_d;
            p_y_q   <= p_y_d;
            p_z_q   <= p_z_d;
        end
    end

    // ---------------- micro-rotation chain ----------------
    cordic_ctl_t          s_ctl [N_STAGES+1];
    logic signed [IW-1:0] s_x   [N_STAGES+1];
    logic signed [IW-1:0] s_y   [N_STAGES+1];
    logic [WIDTH-1:0]     s_z   [N_STAGES+1];

    assign s_ctl[0] = p_ctl_q;
    assign s_x[0]   = p_x_q;
    assign s_y[0]   = p_y_q;
    assign s_z[0]   = p_z_q;

    for (genvar i = 0; i < N_STAGES; i++) begin : g_stage
        cordic_stage #(
            .STAGE_IDX (i),
            .XY_W      (IW),
            .Z_W       (WIDTH)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .advance (advance),
            .ctl_in  (s_ctl[i]),
            .x_in    (s_x[i]),
            .y_in    (s_y[i]),
            .z_in    (s_z[i]),
            .ctl_out (s_ctl[i+1]),
            .x_out   (s_x[i+1]),
            .y_out   (s_y[i+1]),
            .z_out   (s_z[i+1])
        );
    end

    // ---------------- optional gain stage ----------------
    cordic_ctl_t          f_ctl;
    logic signed [IW-1:0] f_x, f_y;
    logic [WIDTH-1:0]     f_z;

    if (GAIN_COMP != 0) begin : g_gain
        localparam logic signed [PW-1:0] K_S = PW'(INV_K_W);

        cordic_ctl_t          g_ctl_d, g_ctl_q;
        logic signed [IW-1:0] g_x_d, g_x_q, g_y_d, g_y_q;
        logic [WIDTH-1:0]     g_z_d, g_z_q;
        logic signed [PW-1:0] x_p, y_p;

        always_comb begin
            x_p     = PW'(s_x[N_STAGES]) * K_S;
            y_p     = PW'(s_y[N_STAGES]) * K_S;
            g_ctl_d = g_ctl_q;
            g_x_d   = g_x_q;
            g_y_d   = g_y_q;
            g_z_d   = g_z_q;
            if (advance) begin
                g_ctl_d = s_ctl[N_STAGES];
                g_x_d   = IW'(x_p >>> (WIDTH - 1));
                g_y_d   = IW'(y_p >>> (WIDTH - 1));
                g_z_d   = s_z[N_STAGES];
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                g_ctl_q <= '0;
                g_x_q   <= '0;
                g_y_q   <= '0;
                g_z_q   <= '0;
            end else begin
                g_ctl_q <= g_ctl_d;
                g_x_q   <= g_x_d;
                g_y_q   <= g_y_d;
                g_z_q   <= g_z_d;
            end
        end

        assign f_ctl = g_ctl_q;
        assign f_x   = g_x_q;
        assign f_y   = g_y_q;
        assign f_z   = g_z_q;
    end else begin : g_nogain
        assign f_ctl = s_ctl[N_STAGES];
        assign f_x   = s_x[N_STAGES];
        assign f_y   = s_y[N_STAGES];
        assign f_z   = s_z[N_STAGES];
    end

    // ---------------- output formatting ----------------
    // Drop guard bits with round-half-up, then clamp symmetrically
    // so the most-negative code never appears.
    function automatic logic [WIDTH-1:0] round_sat(
        input logic signed [IW-1:0] v
    );
        logic signed [IW:0] r;
        r = ((IW+1)'(v) + RND) >>> GUARD;
        if (r > SAT_HI) begin
            r = SAT_HI;
        end else if (r < SAT_LO) begin
            r = SAT_LO;
        end
        return r[WIDTH-1:0];
    endfunction

    assign out_valid = f_ctl.valid;
    assign mode_out  = f_ctl.mode;
    assign x_out     = round_sat(f_x);
    assign y_out     = round_sat(f_y);
    assign z_out     = f_z;

endmodule
